// File: rtl/tx_shift_engine.sv
// tx_shift_engine: SCL-sampled serial transmit shifter with a one-word holding buffer
module tx_shift_engine #(
  parameter int DATA_W = 32,
  parameter bit MSB_FIRST = 1,
  parameter bit IDLE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       scl_in,
  input  logic                       enable,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       load_valid,
  output logic                       load_ready,
  output logic                       sda_o,
  output logic                       busy,
  output logic [$clog2(DATA_W)-1:0]  bit_cnt,
  output logic                       word_done,
  output logic                       underrun
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic s1, s2, d, hold_full;
  logic [DATA_W-1:0] hold, shreg, shifted;
  logic fall, hold_head, shifted_head;
  assign fall = d & ~s2;
  assign shifted = MSB_FIRST ? shreg << 1 : shreg >> 1;
  assign hold_head = MSB_FIRST ? hold[DATA_W-1] : hold[0];
  assign shifted_head = MSB_FIRST ? shifted[DATA_W-1] : shifted[0];
  assign load_ready = ~hold_full;
  assign busy = state == SHIFT;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      d <= 1'b1;
      state <= IDLE;
      hold <= '0;
      hold_full <= 1'b0;
      shreg <= '0;
      bit_cnt <= '0;
      sda_o <= IDLE_LEVEL;
      word_done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      s1 <= scl_in;
      s2 <= s1;
      d <= s2;
      word_done <= 1'b0;
      underrun <= 1'b0;
      if (load_valid && !hold_full) begin
        hold <= data_in;
        hold_full <= 1'b1;
      end
      if (fall && enable) begin
        if (state == IDLE) begin
          if (hold_full) begin
            shreg <= hold;
            hold_full <= 1'b0;
            bit_cnt <= CW'(DATA_W - 1);
            sda_o <= hold_head;
            state <= SHIFT;
          end
        end else if (bit_cnt != '0) begin
          shreg <= shifted;
          bit_cnt <= bit_cnt - 1'b1;
          sda_o <= shifted_head;
        end else begin
          word_done <= 1'b1;
          if (hold_full) begin
            shreg <= hold;
            hold_full <= 1'b0;
            bit_cnt <= CW'(DATA_W - 1);
            sda_o <= hold_head;
          end else begin
            underrun <= 1'b1;
            sda_o <= IDLE_LEVEL;
            state <= IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tx_shift_engine.sv
// tb_tx_shift_engine: scoreboard bench for a 32-bit MSB-first and an 8-bit LSB-first engine
module tb_tx_shift_engine;
  logic clk = 0, rst = 1, en = 1;
  logic scl_a = 1, lv_a = 0, rdy_a, sda_a, busy_a, wd_a, ur_a;
  logic [31:0] data_a = '0;
  logic [4:0] bc_a;
  logic scl_b = 1, lv_b = 0, rdy_b, sda_b, busy_b, wd_b, ur_b;
  logic [7:0] data_b = '0;
  logic [2:0] bc_b;
  int n_cmp = 0, n_err = 0;
  bit exp_q[$];
  bit m_act = 0, m_hold = 0, m_sda = 1;
  int m_cnt = 0;
  always #5 clk = ~clk;
  tx_shift_engine #(.DATA_W(32), .MSB_FIRST(1), .IDLE_LEVEL(1)) dut_a (
    .clk(clk), .rst(rst), .scl_in(scl_a), .enable(en), .data_in(data_a),
    .load_valid(lv_a), .load_ready(rdy_a), .sda_o(sda_a), .busy(busy_a),
    .bit_cnt(bc_a), .word_done(wd_a), .underrun(ur_a));
  tx_shift_engine #(.DATA_W(8), .MSB_FIRST(0), .IDLE_LEVEL(1)) dut_b (
    .clk(clk), .rst(rst), .scl_in(scl_b), .enable(1'b1), .data_in(data_b),
    .load_valid(lv_b), .load_ready(rdy_b), .sda_o(sda_b), .busy(busy_b),
    .bit_cnt(bc_b), .word_done(wd_b), .underrun(ur_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic scl_set(input bit b, input bit v);
    if (b) scl_b = v;
    else scl_a = v;
  endtask
  task automatic load_a(input logic [31:0] w);
    data_a = w;
    lv_a = 1;
    clks(1);
    lv_a = 0;
    m_hold = 1;
    for (int i = 31; i >= 0; i--) exp_q.push_back(w[i]);
    chk("a_ready_low", rdy_a, 0);
  endtask
  task automatic step_a();
    bit ed, eu, adv;
    ed = 0;
    eu = 0;
    adv = 0;
    scl_set(0, 0);
    clks(3);
    if (en) begin
      if (!m_act) begin
        if (m_hold) begin
          m_act = 1;
          m_hold = 0;
          m_cnt = 31;
          adv = 1;
        end
      end else if (m_cnt != 0) begin
        m_cnt--;
        adv = 1;
      end else begin
        ed = 1;
        if (m_hold) begin
          m_hold = 0;
          m_cnt = 31;
          adv = 1;
        end else begin
          eu = 1;
          m_act = 0;
          m_sda = 1;
        end
      end
    end
    if (adv) m_sda = exp_q.size() != 0 ? exp_q.pop_front() : 1'b1;
    chk("a_sda", sda_a, m_sda);
    chk("a_busy", busy_a, m_act);
    chk("a_bit_cnt", bc_a, m_cnt);
    chk("a_ready", rdy_a, !m_hold);
    chk("a_word_done", wd_a, ed);
    chk("a_underrun", ur_a, eu);
    clks(1);
    chk("a_done_width", wd_a | ur_a, 0);
    scl_set(0, 1);
    clks(3);
  endtask
  task automatic do_reset();
    rst = 1;
    clks(1);
    chk("rst_sda", sda_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_ready", rdy_a, 1);
    chk("rst_bit_cnt", bc_a, 0);
    chk("rst_pulses", {wd_a, ur_a}, 0);
    chk("rst_b_sda", sda_b, 1);
    chk("rst_b_ready", rdy_b, 1);
    rst = 0;
    m_act = 0;
    m_hold = 0;
    m_cnt = 0;
    m_sda = 1;
    exp_q.delete();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit qb[$];
    bit eb;
    logic [7:0] wb [2] = '{8'h01, 8'h96};
    clks(3);
    do_reset();
    load_a(32'hA500_0001);
    repeat (33) step_a();
    load_a(32'hFFFF_0000);
    step_a();
    load_a(32'h0000_FFFF);
    repeat (64) step_a();
    load_a(32'h1234_5678);
    repeat (11) step_a();
    en = 0;
    load_a(32'hCAFE_F00D);
    repeat (5) step_a();
    en = 1;
    repeat (54) step_a();
    load_a(32'h0F0F_0F0F);
    repeat (5) step_a();
    do_reset();
    load_a(32'h8000_0001);
    repeat (33) step_a();
    load_a(32'h55AA_55AA);
    repeat (3) step_a();
    @(posedge clk);
    #1 scl_a = 0;
    #3 scl_a = 1;
    clks(5);
    chk("glitch_sda", sda_a, m_sda);
    chk("glitch_bit_cnt", bc_a, m_cnt);
    repeat (30) step_a();
    scl_a = 0;
    rst = 1;
    clks(3);
    do_reset();
    clks(5);
    chk("rel_sda", sda_a, 1);
    chk("rel_busy", busy_a, 0);
    chk("rel_pulses", {wd_a, ur_a}, 0);
    scl_a = 1;
    clks(3);
    load_a(32'hDEAD_BEEF);
    repeat (33) step_a();
    for (int w = 0; w < 2; w++) begin
      data_b = wb[w];
      lv_b = 1;
      clks(1);
      lv_b = 0;
      chk("b_ready_low", rdy_b, 0);
      for (int i = 0; i < 8; i++) qb.push_back(wb[w][i]);
      for (int k = 1; k <= 9; k++) begin
        scl_set(1, 0);
        clks(3);
        eb = qb.size() != 0 ? qb.pop_front() : 1'b1;
        chk("b_sda", sda_b, eb);
        chk("b_bit_cnt", bc_b, k <= 8 ? 8 - k : 0);
        chk("b_busy", busy_b, k <= 8);
        chk("b_done", {wd_b, ur_b}, k == 9 ? 2'b11 : 2'b00);
        scl_set(1, 1);
        clks(3);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
